clock_glyph_streamer: RTL and testbench
=======================================

# clock_glyph_streamer

Parametrised time-of-day display engine. Keeps hh:mm:ss, and on each refresh request renders the 8-character string "HH:MM:SS" by reading glyph rows from the external character ROM. It emits one pixel word per bit over a valid/ready stream. It replaces the fixed 13×24 clock renderer and adds ROM-size parameters, 12/24-hour display, a time-load port, output back-pressure and a frame-done pulse.

## Interface
- GLYPH_W, 13: bits per ROM row (glyph width), 2..32
- GLYPH_H, 24: rows per glyph; glyph g row r is at ROM address g*GLYPH_H + r
- ADDR_W, 9: ROM address width; must satisfy 12*GLYPH_H <= 2^ADDR_W
- PIX_W, 24: pixel word width; set bit → all ones, clear bit → all zeros
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- tick_sec  in  1  one-cycle pulse: advance time by one second
- load  in  1  one-cycle pulse: load load_time
- load_time  in  24  binary {hh[23:16], mm[15:8], ss[7:0]}; hh 0..23, mm/ss 0..59
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour
- refresh  in  1  request one frame; sampled only in IDLE
- rom_addr  out  ADDR_W  ROM address; synchronous ROM, data valid the cycle after the address
- rom_data  in  GLYPH_W  ROM row; bit GLYPH_W-1 is the leftmost pixel
- pix_data  out  PIX_W  current pixel word
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  sink accepts pix_data when pix_valid & pix_ready
- busy  out  1  high from the cycle after refresh is accepted until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Glyph codes: 0–9 are digits, 10 is colon, 11 is blank.
- Timekeeping is independent of rendering. load has priority over tick_sec. A tick carries ss 59→0 into mm, mm 59→0 into hh, and hh 23→0.
- Character sequence: H1 H0 : M1 M0 : S1 S0.
  - 24-hour mode: hour digits come straight from hh.
  - 12-hour mode: hh 0→12 and 13..23→1..11. A zero hour tens digit is shown as blank (11).
- Snapshot: the 8 glyph codes are latched when refresh is accepted. Ticks, loads or a mode change during a frame do not alter that frame.
- States:
  - IDLE: refresh → ADDR.
  - ADDR: drive rom_addr = code*GLYPH_H + row → FETCH.
  - FETCH: wait one cycle → LOAD.
  - LOAD: capture rom_data into the row shift register; col = GLYPH_W-1 → SHIFT.
  - SHIFT: pix_valid = 1; pix_data = {PIX_W{row[col]}}. On accept:
    - if col > 0, decrement col;
    - else if row < GLYPH_H-1, row+1 → ADDR;
    - else if char < 7, char+1, row 0 → ADDR;
    - else → DONE.
  - DONE: frame_done = 1 → IDLE.
- Pixel order: per character, rows top to bottom, columns MSB first. Total pixels per frame = 8*GLYPH_H*GLYPH_W.
- refresh outside IDLE is ignored, not queued.
- Reset values: time 00:00:00; state IDLE; rom_addr 0; pix_data 0; pix_valid 0; busy 0; frame_done 0; all counters 0.

## Timing
- refresh accepted at edge n: busy=1 and ADDR at n+1, first pix_valid at n+4. Each row costs 3 overhead cycles plus GLYPH_W accepted pixels.
- With pix_ready held high, a frame takes 8*GLYPH_H*(GLYPH_W+3)+2 cycles from refresh to frame_done.
- While pix_valid=1 and pix_ready=0, pix_data and all counters hold. pix_valid never drops before acceptance.
- frame_done is high for exactly one cycle, in which busy=0 and pix_valid=0. A refresh in that cycle is ignored; a refresh in the next cycle (IDLE) is accepted.
- tick_sec and load take effect on the next edge. Simultaneous tick_sec and load: the loaded value wins and the tick is lost.
- reset asserted mid-frame aborts immediately. There is no frame_done, and outputs return to reset values asynchronously.

## Configuration
- CLOCK_STREAMER_BLINK_EN defined: both colon positions use glyph 11 (blank) when the snapshot ss is odd, and glyph 10 when it is even.
- Not defined: colons are always glyph 10.

## Test plan
- Load 23:59:59, 24-hour, one tick_sec → time 00:00:00. Refresh → ROM row-0 addresses per character 0,0,240,0,0,240,0,0 (defaults).
- Load 13:05:09, mode_12h=1, refresh → codes 11,1,10,0,5,10,0,9. A bit-set ROM row gives pix_data 24'hFFFFFF; a bit-clear row gives 24'h000000.
- pix_ready high throughout (defaults) → exactly 2496 accepted pixels, and frame_done in cycle 8*24*16+2 = 3074 after refresh.
- Random pix_ready stalls → pix_data stable across every stall; pixel sequence identical to the no-stall run.
- tick_sec and load pulses during a frame → frame content unchanged. A refresh during busy is ignored; a second frame shows the updated time.
- reset asserted at pixel 100 → pix_valid=0, busy=0, time 00:00:00 immediately; next refresh gives a full correct frame. With BLINK_EN and ss=7 → colon rows use address 264.

Source files
------------

// File: rtl/clock_glyph_streamer.sv
// rtl/clock_glyph_streamer.sv - hh:mm:ss keeper that streams "HH:MM:SS" glyph pixels from a char ROM
// Optional build macro CLOCK_STREAMER_BLINK_EN blanks both colons while the snapshot seconds are odd.
module clock_glyph_streamer #(
    parameter int GLYPH_W = 13,
    parameter int GLYPH_H = 24,
    parameter int ADDR_W  = 9,
    parameter int PIX_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_sec,
    input  logic               load,
    input  logic [23:0]        load_time,
    input  logic               mode_12h,
    input  logic               refresh,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               frame_done
);
    localparam int CW = $clog2(GLYPH_W);
    localparam int RW = $clog2(GLYPH_H + 1);
    localparam logic [ADDR_W-1:0] GH = ADDR_W'(GLYPH_H);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FETCH, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state_q;
    logic [7:0]        hh_q, mm_q, ss_q;
    logic [7:0][3:0]   codes_q, live_codes;
    logic [2:0]        char_q;
    logic [RW-1:0]     rowcnt_q;
    logic [CW-1:0]     col_q;
    logic [GLYPH_W-1:0] row_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [PIX_W-1:0]  pix_data_q;
    logic              pix_valid_q, busy_q, frame_done_q;
    logic [7:0]        hour_disp, hb, mb, sb;
    logic [3:0]        colon;

    // Values stay below 70, so six conditional subtractions always finish the split.
    function automatic logic [7:0] bcd(input logic [7:0] v);
        logic [7:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (r >= 8'd10) begin
                r = r - 8'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'd0} + r;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] code, input logic [RW-1:0] row);
        return ADDR_W'(code) * GH + ADDR_W'(row);
    endfunction

`ifdef CLOCK_STREAMER_BLINK_EN
    assign colon = ss_q[0] ? 4'd11 : 4'd10;
`else
    assign colon = 4'd10;
`endif

    always_comb begin
        hour_disp = hh_q;
        if (mode_12h) begin
            if (hh_q == 8'd0)
                hour_disp = 8'd12;
            else if (hh_q > 8'd12)
                hour_disp = hh_q - 8'd12;
        end
        hb = bcd(hour_disp);
        mb = bcd(mm_q);
        sb = bcd(ss_q);
        live_codes[0] = (mode_12h && hb[7:4] == 4'd0) ? 4'd11 : hb[7:4];
        live_codes[1] = hb[3:0];
        live_codes[2] = colon;
        live_codes[3] = mb[7:4];
        live_codes[4] = mb[3:0];
        live_codes[5] = colon;
        live_codes[6] = sb[7:4];
        live_codes[7] = sb[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_q <= 8'd0;
            mm_q <= 8'd0;
            ss_q <= 8'd0;
        end else if (load) begin
            hh_q <= load_time[23:16];
            mm_q <= load_time[15:8];
            ss_q <= load_time[7:0];
        end else if (tick_sec) begin
            if (ss_q == 8'd59) begin
                ss_q <= 8'd0;
                if (mm_q == 8'd59) begin
                    mm_q <= 8'd0;
                    hh_q <= (hh_q == 8'd23) ? 8'd0 : hh_q + 8'd1;
                end else begin
                    mm_q <= mm_q + 8'd1;
                end
            end else begin
                ss_q <= ss_q + 8'd1;
            end
        end
    end

    // rom_addr is registered on entry to ADDR so the ROM sees it for the whole ADDR cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            codes_q      <= '0;
            char_q       <= 3'd0;
            rowcnt_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            rom_addr_q   <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (refresh) begin
                        codes_q    <= live_codes;
                        char_q     <= 3'd0;
                        rowcnt_q   <= '0;
                        rom_addr_q <= addr_of(live_codes[0], '0);
                        busy_q     <= 1'b1;
                        state_q    <= S_ADDR;
                    end
                end
                S_ADDR:  state_q <= S_FETCH;
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    row_q       <= rom_data;
                    col_q       <= CW'(GLYPH_W - 1);
                    pix_data_q  <= {PIX_W{rom_data[GLYPH_W-1]}};
                    pix_valid_q <= 1'b1;
                    state_q     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (pix_ready) begin
                        if (col_q != '0) begin
                            col_q      <= col_q - 1'b1;
                            pix_data_q <= {PIX_W{row_q[col_q - 1'b1]}};
                        end else begin
                            pix_valid_q <= 1'b0;
                            pix_data_q  <= '0;
                            if (rowcnt_q != RW'(GLYPH_H - 1)) begin
                                rowcnt_q   <= rowcnt_q + 1'b1;
                                rom_addr_q <= addr_of(codes_q[char_q], rowcnt_q + 1'b1);
                                state_q    <= S_ADDR;
                            end else if (char_q != 3'd7) begin
                                char_q     <= char_q + 3'd1;
                                rowcnt_q   <= '0;
                                rom_addr_q <= addr_of(codes_q[char_q + 3'd1], '0);
                                state_q    <= S_ADDR;
                            end else begin
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                                state_q      <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_clock_glyph_streamer.sv
// tb/tb_clock_glyph_streamer.sv - scoreboard bench for clock_glyph_streamer with a synchronous ROM model
module tb_clock_glyph_streamer;
    typedef logic [7:0][3:0] codes_t;

`ifdef CLOCK_STREAMER_BLINK_EN
    localparam logic [3:0] COL_ODD = 4'd11;
`else
    localparam logic [3:0] COL_ODD = 4'd10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_sec = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_time = 24'd0;
    logic        mode_12h = 1'b0;
    logic        refresh = 1'b0;
    logic [8:0]  rom_addr;
    logic [12:0] rom_data = 13'd0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_fail = 0;
    int acc_total = 0;
    bit stall = 1'b0;

    logic [23:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b1;
    logic [23:0] prev_d = 24'd0;

    clock_glyph_streamer dut (
        .clk(clk), .reset(reset), .tick_sec(tick_sec), .load(load), .load_time(load_time),
        .mode_12h(mode_12h), .refresh(refresh), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] rom_val(input int a);
        int x;
        x = a * 2897 + 1234;
        return 13'(x ^ (x >> 7));
    endfunction

    always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

    always @(posedge clk) begin
        #1;
        pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic codes_t mk(input logic [3:0] a, b, c, d, e, f, g, h);
        codes_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        r[4] = e; r[5] = f; r[6] = g; r[7] = h;
        return r;
    endfunction

    task automatic push_frame(input codes_t c);
        int a;
        logic [12:0] v;
        for (int ch = 0; ch < 8; ch++) begin
            for (int r = 0; r < 24; r++) begin
                a = int'(c[ch]) * 24 + r;
                addr_q.push_back(32'(a));
                v = rom_val(a);
                for (int col = 12; col >= 0; col--)
                    exp_q.push_back(v[col] ? 24'hFFFFFF : 24'h000000);
            end
        end
    endtask

    // Monitor samples at negedge; inputs change just after posedge, so valid&ready here is the handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            prev_v = 1'b0;
            prev_r = 1'b1;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid_held", 32'(pix_valid), 32'd1);
                chk("stall_data_held", 32'(pix_data), 32'(prev_d));
            end
            if (pix_valid && !prev_v) begin
                if (addr_q.size() == 0) chk("row_addr_extra", 32'(addr_q.size()), 32'd1);
                else chk("row_addr", 32'(rom_addr), addr_q.pop_front());
            end
            if (pix_valid && pix_ready) begin
                acc_total++;
                if (exp_q.size() == 0) chk("pix_extra", 32'(exp_q.size()), 32'd1);
                else chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
            end
            if (frame_done) begin
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_valid_low", 32'(pix_valid), 32'd0);
            end
            prev_v = pix_valid;
            prev_r = pix_ready;
            prev_d = pix_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input codes_t c, input bit chk_t, input bit inj);
        int cyc;
        int first_v;
        push_frame(c);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        cyc = 1;
        first_v = 0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!frame_done && cyc < 20000) begin
            step();
            cyc++;
            if (pix_valid && first_v == 0) first_v = cyc;
            if (inj) begin
                case (cyc)
                    50:  tick_sec = 1'b1;
                    51:  tick_sec = 1'b0;
                    100: begin load = 1'b1; load_time = 24'h020304; mode_12h = 1'b0; end
                    101: load = 1'b0;
                    150: refresh = 1'b1;
                    151: refresh = 1'b0;
                    default: ;
                endcase
            end
        end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        if (chk_t) begin
            chk("frame_cycles", 32'(cyc + 1), 32'(8 * 24 * 16 + 2));
            chk("first_valid_cycle", 32'(first_v), 32'd4);
        end
        chk("frame_pixels_left", 32'(exp_q.size()), 32'd0);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        chk("refresh_in_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int w;
        step();
        step();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        step();

        // 23:59:59 + tick wraps to 00:00:00; colons at address 240
        load_time = 24'h173B3B; load = 1'b1; step(); load = 1'b0;
        tick_sec = 1'b1; step(); tick_sec = 1'b0;
        do_frame(mk(0, 0, 10, 0, 0, 10, 0, 0), 1'b1, 1'b0);

        // 13:05:09 in 12h mode, stalls, mid-frame tick/load/mode/refresh
        load_time = 24'h0D0509; load = 1'b1; mode_12h = 1'b1; step(); load = 1'b0;
        stall = 1'b1;
        do_frame(mk(11, 1, COL_ODD, 0, 5, COL_ODD, 0, 9), 1'b0, 1'b1);

        // second frame picks up the load made during the previous one: 02:03:04, 24h
        do_frame(mk(0, 2, 10, 0, 3, 10, 0, 4), 1'b0, 1'b0);
        stall = 1'b0;

        // simultaneous load and tick: load wins -> 00:59:59, 12h shows hour 12
        load_time = 24'h003B3B; load = 1'b1; tick_sec = 1'b1; mode_12h = 1'b1; step();
        load = 1'b0; tick_sec = 1'b0;
        do_frame(mk(1, 2, COL_ODD, 5, 9, COL_ODD, 5, 9), 1'b1, 1'b0);

        // abort at pixel 100 with reset
        load_time = 24'h0C0007; load = 1'b1; mode_12h = 1'b0; step(); load = 1'b0;
        push_frame(mk(1, 2, COL_ODD, 0, 0, COL_ODD, 0, 7));
        base = acc_total;
        refresh = 1'b1; step(); refresh = 1'b0;
        w = 0;
        while ((acc_total - base) < 100 && w < 5000) begin
            step();
            w++;
        end
        chk("abort_point_reached", 32'((acc_total - base) >= 100), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_pix_valid", 32'(pix_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frame_done", 32'(frame_done), 32'd0);
        chk("abort_pix_data", 32'(pix_data), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // time was cleared by reset
        do_frame(mk(0, 0, 10, 0, 0, 10, 0, 0), 1'b1, 1'b0);

        // odd seconds: colons go blank (address 264) only with blinking built in
        load_time = 24'h000007; load = 1'b1; step(); load = 1'b0;
        do_frame(mk(0, 0, COL_ODD, 0, 0, COL_ODD, 0, 7), 1'b1, 1'b0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
